// File: rtl/decoder_scan_nbit.sv
// decoder_scan_nbit
//   N-bit to 2**N one-hot decoder with an auto-scan mode. In direct mode the
//   registered output tracks 1<<a. In scan mode a start pulse walks the
//   one-hot output through all 2**N positions, beginning at a, holding each
//   position for DWELL cycles, then pulses done for one cycle.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   a      - decode select (direct) / starting index (scan)
//   enable - output enable; low aborts a running scan
//   mode   - 0 = direct decode, 1 = auto-scan
//   start  - scan launch request (IDLE, mode=1, enable=1 only)
//   y      - registered one-hot output or all-zero
//   busy   - high while scanning
//   done   - one-cycle pulse on normal scan completion
module decoder_scan_nbit #(
  parameter int N     = 3,
  parameter int DWELL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    a,
  input  logic            enable,
  input  logic            mode,
  input  logic            start,
  output logic [2**N-1:0] y,
  output logic            busy,
  output logic            done
);

  localparam int W  = 2**N;
  localparam int CW = $clog2(DWELL) + 1;

  localparam logic [W-1:0]  ONE       = W'(1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
  localparam logic [N:0]    STEP_END  = (N+1)'(W - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [N-1:0]  index;
  logic [N-1:0]  index_nxt;
  logic [CW-1:0] dwell;
  logic [N:0]    step;

  // Natural N-bit wrap gives the 2**N-1 -> 0 rollover.
  always_comb begin
    index_nxt = index + N'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
      dwell <= '0;
      step  <= '0;
      y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (mode && enable && start) begin
            state <= SCAN;
            index <= a;
            dwell <= '0;
            step  <= '0;
            y     <= ONE << a;
            busy  <= 1'b1;
          end else if (!mode && enable) begin
            y    <= ONE << a;
            busy <= 1'b0;
          end else begin
            y    <= '0;
            busy <= 1'b0;
          end
        end
        SCAN: begin
          if (!enable) begin
            state <= IDLE;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (dwell == DWELL_END) begin
            dwell <= '0;
            if (step == STEP_END) begin
              state <= IDLE;
              y     <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              step  <= step + (N+1)'(1);
              index <= index_nxt;
              y     <= ONE << index_nxt;
            end
          end else begin
            dwell <= dwell + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          y     <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
